pattern_loader: RTL and testbench
=================================

PATTERN_LOADER -- requirements
Module: pattern_loader

Interface
REQ-001 Parameter: ROWS, default 8, number of board rows written per load.
REQ-002 Parameter: WIDTH, default 8, cells per row (bits per row word).
REQ-003 Port: ph1  input  1  single clock; all state updates on rising edge of ph1.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request to begin a new board load.
REQ-006 Port: bit_in  input  1  serial cell value (1 = live).
REQ-007 Port: bit_valid  input  1  bit_in is valid this cycle.
REQ-008 Port: bit_ready  output  1  loader accepts a bit this cycle.
REQ-009 Port: wr_grant  input  1  board memory accepts the presented write this cycle (write window open).
REQ-010 Port: wr_en  output  1  row write request.
REQ-011 Port: wr_addr  output  $clog2(ROWS)  row being written.
REQ-012 Port: wr_data  output  WIDTH  row contents.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: done  output  1  one-cycle pulse when the final row write is granted.
REQ-015 Port: err  output  1  sticky; set when start arrives while busy.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT, WRITE, DONE.
REQ-017 IDLE: bit_ready=0, wr_en=0; start=1 SHALL move to SHIFT with row=0 and bitcnt=0.
REQ-018 SHIFT: bit_ready=1; a bit SHALL be accepted only when bit_valid and bit_ready are both 1.
REQ-019 Bits SHALL be accepted MSB first: the first accepted bit of a row lands in wr_data[WIDTH-1], the last in wr_data[0].
REQ-020 On acceptance of the WIDTH-th bit of a row, the FSM SHALL go to WRITE; bit_ready SHALL be 0 in WRITE.
REQ-021 WRITE: wr_en=1 with wr_addr=row and wr_data=assembled row, all held stable until the cycle wr_grant=1.
REQ-022 On grant with row<ROWS-1: row increments, bitcnt clears, next state SHIFT.
REQ-023 On grant with row=ROWS-1: next state DONE; row SHALL NOT wrap to 0 before DONE.
REQ-024 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-025 bit_valid with no bit_ready SHALL be ignored; gaps in bit_valid SHALL stall SHIFT without loss.
REQ-026 wr_en SHALL never be asserted outside WRITE; exactly ROWS writes per completed load.
REQ-027 start while busy SHALL abort the load: next state SHIFT, row=0, bitcnt=0, err set; the abandoned partial row is never written.
REQ-028 Latency with start at cycle 0, bit_valid and wr_grant held 1: row r write granted at cycle 9(r+1); done at cycle 73 (WIDTH=ROWS=8).

Reset
REQ-029 reset SHALL force IDLE, row=0, bitcnt=0, shift register=0, and all outputs (bit_ready, wr_en, wr_addr, wr_data, busy, done, err) to 0.
REQ-030 reset SHALL take priority over start, bit_valid and wr_grant in the same cycle; a reset mid-load SHALL produce no further write.

Structure
REQ-031 ROWS, WIDTH and the state enum SHALL live in the shared package cgol_pkg.
REQ-032 The serial-to-row assembly SHALL be a sub-module row_shifter (WIDTH-bit shift register with enable and clear).

Verification
REQ-033 Reset then start, stream 64 bits of a glider pattern, grant always 1 -> writes rows 0..7 with the exact bytes, done at cycle 73.
REQ-034 Stream bits with bit_valid toggling 1/0 -> identical row data; completion delayed by exactly the number of idle cycles.
REQ-035 wr_grant held 0 for 5 cycles on row 3 -> wr_en/wr_addr=3/wr_data stable for 6 cycles, no bit accepted meanwhile.
REQ-036 start pulse after 20 bits -> err=1, next write is row 0 containing bits sent after the restart, 8 writes total.
REQ-037 reset asserted during WRITE of row 5 -> next cycle all outputs 0, state IDLE, no row 5 write granted.

Source files
------------

// File: rtl/cgol_pkg.sv
// Shared board geometry and loader state encoding
// for the Game-of-Life pattern loader.
package cgol_pkg;

  localparam int ROWS  = 8;
  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/row_shifter.sv
// Serial-to-row assembler: MSB-first shift register
// with synchronous clear (clear wins over enable).
module row_shifter #(
  parameter int WIDTH = cgol_pkg::WIDTH
) (
  input  logic             ph1,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge ph1) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], d};
    end
  end

endmodule

// File: rtl/pattern_loader.sv
// Loads a ROWS x WIDTH board from a serial bit stream
// and writes it row by row into board memory.
module pattern_loader #(
  parameter int ROWS  = cgol_pkg::ROWS,
  parameter int WIDTH = cgol_pkg::WIDTH
) (
  input  logic                    ph1,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  input  logic                    wr_grant,
  output logic                    wr_en,
  output logic [$clog2(ROWS)-1:0] wr_addr,
  output logic [WIDTH-1:0]        wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  import cgol_pkg::*;

  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  state_t        state;
  logic [AW-1:0] row;
  logic [CW-1:0] bitcnt;
  logic          take;
  logic          granted;
  logic          sh_clr;

  assign take    = bit_valid & bit_ready;
  assign granted = (state == WRITE) & wr_grant;
  assign wr_addr = row;

  // Any start (fresh or abort) discards the partial row.
  assign sh_clr = reset | start | granted;

  row_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .ph1(ph1),
    .clr(sh_clr),
    .en (take),
    .d  (bit_in),
    .q  (wr_data)
  );

  always_ff @(posedge ph1) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      bitcnt    <= '0;
      bit_ready <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && state != IDLE) begin
        err       <= 1'b1;
        state     <= SHIFT;
        row       <= '0;
        bitcnt    <= '0;
        bit_ready <= 1'b1;
        wr_en     <= 1'b0;
        busy      <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state     <= SHIFT;
              row       <= '0;
              bitcnt    <= '0;
              bit_ready <= 1'b1;
              busy      <= 1'b1;
            end
          end
          SHIFT: begin
            if (take) begin
              if (bitcnt == LAST_BIT) begin
                state     <= WRITE;
                bitcnt    <= '0;
                bit_ready <= 1'b0;
                wr_en     <= 1'b1;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end
          end
          WRITE: begin
            if (wr_grant) begin
              wr_en <= 1'b0;
              if (row == LAST_ROW) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                row       <= row + 1'b1;
                state     <= SHIFT;
                bit_ready <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: latency, stalls,
// back-pressure, abort and mid-load reset.
module tb_pattern_loader;

  localparam logic [63:0] GLIDER = 64'h4020_E000_0000_0000;
  localparam logic [63:0] P2     = 64'hA5C3_0F81_7E3C_9966;
  localparam logic [63:0] P3     = 64'h0123_4567_89AB_CDEF;

  logic       ph1 = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       wr_grant = 1'b0;
  logic       bit_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;

  int errs = 0;
  int checks = 0;
  int nw;
  int wa[16];
  logic [7:0] wd[16];
  int wc[16];
  int done_cyc;
  int idle;
  int stall_cyc;

  pattern_loader #(
    .ROWS (8),
    .WIDTH(8)
  ) dut (
    .ph1      (ph1),
    .reset    (reset),
    .start    (start),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .wr_grant (wr_grant),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 ph1 = ~ph1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, 64'(bit_ready), 64'd0);
    chk({tag, "_wen"}, 64'(wr_en), 64'd0);
    chk({tag, "_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic chk_rows(input logic [63:0] pat);
    chk("nwrites", 64'(nw), 64'd8);
    for (int r = 0; r < 8; r++) begin
      chk("wr_addr", 64'(wa[r]), 64'(r));
      chk("wr_data", 64'(wd[r]), 64'(pat[63-8*r -: 8]));
    end
  endtask

  // One load: start, stream bits, record granted writes.
  task automatic drive(input logic [63:0] pat,
                       input logic [63:0] pre,
                       input bit toggle,
                       input int stall_row,
                       input int abort_at,
                       input int rst_row);
    int idx;
    int stall;
    bit acc;
    bit fin;
    bit aborted;
    logic [63:0] src;
    idx = 0;
    stall = 0;
    fin = 0;
    aborted = 0;
    nw = 0;
    done_cyc = -1;
    idle = 0;
    stall_cyc = 0;
    src = (abort_at >= 0) ? pre : pat;
    start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b0;
    wr_grant = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 2000 && !fin; c++) begin
      wr_grant = 1'b1;
      bit_valid = 1'b0;
      acc = 0;
      if (wr_en && int'(wr_addr) == stall_row) begin
        stall_cyc++;
        chk("stall_data", 64'(wr_data),
            64'(pat[63-8*stall_row -: 8]));
        chk("stall_rdy", 64'(bit_ready), 64'd0);
        if (stall < 5) begin
          wr_grant = 1'b0;
          stall++;
        end
      end
      if (wr_en && int'(wr_addr) == rst_row) begin
        reset = 1'b1;
        bit_valid = 1'b1;
      end else if (abort_at >= 0 && !aborted &&
                   idx == abort_at && bit_ready) begin
        chk("pre_writes", 64'(nw), 64'd2);
        nw = 0;
        start = 1'b1;
        aborted = 1;
        idx = 0;
        src = pat;
      end else begin
        bit_valid = (idx < 64) && (!toggle || c % 2 == 1);
        bit_in = (idx < 64) ? src[63-idx] : 1'b0;
        acc = bit_valid && bit_ready;
        if (bit_ready && !bit_valid) idle++;
      end
      if (wr_en && wr_grant && !reset && nw < 16) begin
        wa[nw] = int'(wr_addr);
        wd[nw] = wr_data;
        wc[nw] = c;
        nw++;
      end
      if (done) begin
        done_cyc = c;
        fin = 1;
      end
      if (reset) fin = 1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      if (acc) idx++;
    end
    bit_valid = 1'b0;
    if (!fin) chk("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    // Reset must win over start/bit_valid/wr_grant.
    reset = 1'b1;
    start = 1'b1;
    bit_valid = 1'b1;
    wr_grant = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    tick();

    // Full-rate load with cycle-exact latency.
    drive(GLIDER, 64'd0, 0, -1, -1, -1);
    chk_rows(GLIDER);
    for (int r = 0; r < 8; r++)
      chk("grant_cyc", 64'(wc[r]), 64'(9 * (r + 1)));
    chk("done_cyc", 64'(done_cyc), 64'd73);
    chk("err_clean", 64'(err), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_pulse", 64'(done), 64'd0);

    // bit_valid every other cycle.
    drive(P2, 64'd0, 1, -1, -1, -1);
    chk_rows(P2);
    chk("idle_cnt", 64'(idle), 64'd56);
    chk("toggle_done", 64'(done_cyc), 64'(73 + idle));

    // Grant withheld for 5 cycles on row 3.
    drive(P3, 64'd0, 0, 3, -1, -1);
    chk_rows(P3);
    chk("stall_cycles", 64'(stall_cyc), 64'd6);
    chk("row3_cyc", 64'(wc[3]), 64'd41);
    chk("row7_cyc", 64'(wc[7]), 64'd77);
    chk("stall_done", 64'(done_cyc), 64'd78);

    // Restart after 20 bits of a different stream.
    drive(P3, ~P3, 0, -1, 20, -1);
    chk_rows(P3);
    chk("abort_err", 64'(err), 64'd1);
    chk("abort_done", 64'(done_cyc), 64'd96);

    // Reset during the row 5 write.
    drive(GLIDER, 64'd0, 0, -1, -1, 5);
    chk_zero("midreset");
    chk("mid_writes", 64'(nw), 64'd5);
    bit_valid = 1'b1;
    wr_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_wen", 64'(wr_en), 64'd0);
      chk("post_busy", 64'(busy), 64'd0);
    end
    bit_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
